// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the I/D-cache memory-port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_DONE} arb_state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} arb_owner_t;

   // Byte-offset width of one line: LINE_WORDS beats of DATA_W/8 bytes each.
   function automatic int offset_bits(input int line_words, input int data_w);
      return $clog2(line_words * data_w / 8);
   endfunction

   localparam int OFFSET_W = offset_bits(4, 32);

endpackage

// File: rtl/mem_arb_burst_cnt.sv
// Beat counter, last-beat flag and beat address generator for one line burst.
module mem_arb_burst_cnt
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int OFF_W      = OFFSET_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] base,
   input  logic              inc,
   output logic              last,
   output logic [ADDR_W-1:0] addr
);

   localparam int BEAT_W = $clog2(LINE_WORDS);
   localparam int STEP_W = $clog2(DATA_W / 8);
   localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;

   logic [ADDR_W-1:0] base_reg;
   logic [BEAT_W-1:0] beat_reg;

   // Base is line-aligned, so the beat offset never carries into it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_reg <= '0;
         beat_reg <= '0;
      end else if (load) begin
         base_reg <= base & LINE_MASK;
         beat_reg <= '0;
      end else if (inc) begin
         beat_reg <= beat_reg + 1'b1;
      end
   end

   assign last = (beat_reg == BEAT_W'(LINE_WORDS - 1));
   assign addr = base_reg + (ADDR_W'(beat_reg) << STEP_W);

endmodule

// File: rtl/mem_arbiter_cache.sv
// Grants the main-memory port to the I- or D-cache one line burst at a time.
// Optional ARB_ROUND_ROBIN_EN: simultaneous requests alternate instead of D-over-I.
module mem_arbiter_cache
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic              ic_gnt,
   output logic              ic_rvalid,
   output logic [DATA_W-1:0] ic_rdata,
   output logic              ic_done,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic              dc_wnext,
   output logic              dc_gnt,
   output logic              dc_rvalid,
   output logic [DATA_W-1:0] dc_rdata,
   output logic              dc_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              arb_busy
);

   localparam int OFF_W = offset_bits(LINE_WORDS, DATA_W);

   arb_state_t        state;
   arb_owner_t        owner;
   logic              we_reg;
   logic              done_i_reg;
   logic              done_d_reg;
   logic              pick_d;
   logic              load;
   logic              inc;
   logic              last;
   logic              xfer;
   logic [ADDR_W-1:0] beat_addr;

`ifdef ARB_ROUND_ROBIN_EN
   arb_owner_t last_owner;
   assign pick_d = dc_req & (~ic_req | (last_owner == OWN_I));
`else
   assign pick_d = dc_req;
`endif

   assign load = (state == ARB_IDLE) & (ic_req | dc_req);
   assign inc  = (state == ARB_XFER) & mem_ready;

   mem_arb_burst_cnt #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .LINE_WORDS (LINE_WORDS),
      .OFF_W      (OFF_W)
   ) u_burst_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .base  (pick_d ? dc_addr : ic_addr),
      .inc   (inc),
      .last  (last),
      .addr  (beat_addr)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ARB_IDLE;
         owner      <= OWN_NONE;
         we_reg     <= 1'b0;
         done_i_reg <= 1'b0;
         done_d_reg <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_owner <= OWN_I;
`endif
      end else begin
         case (state)
            ARB_IDLE: begin
               if (ic_req | dc_req) begin
                  state  <= ARB_XFER;
                  owner  <= pick_d ? OWN_D : OWN_I;
                  we_reg <= pick_d & dc_we;
               end
            end
            ARB_XFER: begin
               if (mem_ready && last) begin
                  state      <= ARB_DONE;
                  done_i_reg <= (owner == OWN_I);
                  done_d_reg <= (owner == OWN_D);
`ifdef ARB_ROUND_ROBIN_EN
                  last_owner <= owner;
`endif
               end
            end
            ARB_DONE: begin
               state      <= ARB_IDLE;
               owner      <= OWN_NONE;
               we_reg     <= 1'b0;
               done_i_reg <= 1'b0;
               done_d_reg <= 1'b0;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign xfer      = (state == ARB_XFER);
   assign ic_gnt    = xfer & (owner == OWN_I);
   assign dc_gnt    = xfer & (owner == OWN_D);
   assign mem_req   = xfer;
   assign mem_we    = dc_gnt & we_reg;
   assign mem_addr  = xfer ? beat_addr : '0;
   assign mem_wdata = mem_we ? dc_wdata : '0;
   assign ic_rvalid = ic_gnt & mem_ready;
   assign dc_rvalid = dc_gnt & ~we_reg & mem_ready;
   assign dc_wnext  = dc_gnt & we_reg & mem_ready;
   assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
   assign dc_rdata  = dc_rvalid ? mem_rdata : '0;
   assign ic_done   = done_i_reg;
   assign dc_done   = done_d_reg;
   assign arb_busy  = (state != ARB_IDLE);

endmodule
